mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous instruction/data SRAM between the core's instruction-fetch (IF) port and its load/store (LS) port.
- One transaction is outstanding at a time.
- LS has default priority; a streak limit stops it from starving fetch.
- Sits between the core pipeline and the unified memory macro. It is instantiated in the core top and exercised by the core testbench.

Parameters:
AW, 32, byte address width of both requester ports
MEM_LATENCY, 1, cycles from mem_en asserted to mem_rdata valid (legal range 1..7)
MAX_LS_STREAK, 4, consecutive LS grants allowed while IF is waiting before IF is forced (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
if_req_valid  in  1  fetch request
if_req_addr  in  AW  fetch byte address
if_req_ready  out  1  fetch request accepted this cycle
if_rsp_valid  out  1  fetch data valid, one-cycle pulse
if_rsp_rdata  out  32  fetch data
ls_req_valid  in  1  load/store request
ls_req_addr  in  AW  load/store byte address
ls_req_we  in  1  1 = store, 0 = load
ls_req_wstrb  in  4  byte write strobes, used only for stores
ls_req_wdata  in  32  store data
ls_req_ready  out  1  LS request accepted this cycle
ls_rsp_valid  out  1  load data valid or store ack, one-cycle pulse
ls_rsp_rdata  out  32  load data; 0 for stores
mem_en  out  1  SRAM access strobe
mem_wstrb  out  4  SRAM byte write enables; 0 = read
mem_addr  out  AW-2  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE; owner, latency counter and streak counter are 0.
  - All outputs are 0.
  - Any in-flight response is dropped and never delivered, even if mem_rdata later becomes valid.
- FSM states: IDLE, WAIT, RESP.
- IDLE grant rules:
  - LS wins if ls_req_valid and (streak < MAX_LS_STREAK or !if_req_valid).
  - Otherwise IF wins if if_req_valid.
  - Otherwise no grant.
- IDLE, grant cycle:
  - The winner's *_req_ready is 1. It is a combinational function of the valids and the state. The loser's ready is 0.
  - Handshake completes when valid and ready are both 1. The requester holds valid and its payload stable until ready.
  - mem_en = 1 for this cycle only.
  - mem_addr = addr[AW-1:2]; the low two address bits are ignored.
  - mem_wstrb = ls_req_wstrb if LS store, else 0.
  - mem_wdata = ls_req_wdata for LS, else 0.
  - Owner is registered. Counter loads MEM_LATENCY-1. Next state is WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, mem_rdata is valid. It is captured into the owner's rsp_rdata register (0 for stores). Next state is RESP.
- RESP:
  - The owner's rsp_valid = 1 for exactly one cycle. Next state is IDLE.
  - rsp_rdata holds its value until the next response.
- Timing: rsp_valid rises MEM_LATENCY+1 cycles after the grant cycle. Minimum spacing between grants is MEM_LATENCY+2 cycles. A request arriving in RESP or WAIT waits with ready = 0.
- Streak counter (4 bits, saturating):
  - Increments on an LS grant while if_req_valid = 1.
  - Clears on any IF grant, and on an LS grant with if_req_valid = 0.
- Simultaneous requests in IDLE: LS wins; the IF request stays pending.
- A requester dropping valid before ready is a protocol violation. A bench assertion flags it; the RTL behaviour is undefined.
- Responses are never reordered or interleaved; only one transaction is ever in flight.

Decomposition:
- Shared package riscv_soc_pkg holds:
  - FSM state encoding: ST_IDLE, ST_WAIT, ST_RESP.
  - Owner encoding: OWN_IF = 0, OWN_LS = 1.
  - Constant XLEN = 32.
- One sub-module, mem_arbiter_grant: combinational priority plus streak decision. Inputs are both valids and the streak count; outputs are grant_if and grant_ls. It is unit-testable on its own.
- The FSM, counters and response registers stay in mem_arbiter.

Test Plan:
- Single IF read, MEM_LATENCY = 1, memory word 3 = 0xDEADBEEF, if_req_addr = 0x0C → mem_en pulse with mem_addr = 3; if_rsp_valid 2 cycles after the grant; if_rsp_rdata = 0xDEADBEEF.
- LS store, addr 0x10, wstrb 4'b0011, wdata 0x12345678 → mem_wstrb = 4'b0011 and mem_addr = 4 on the grant cycle; ls_rsp_valid with ls_rsp_rdata = 0; a following load of 0x10 returns 0x????5678 with the upper half unchanged.
- IF and LS valid in the same cycle → LS granted first; IF granted in the first IDLE cycle after the LS response; both responses returned in that order.
- Both valid continuously, MAX_LS_STREAK = 4 → grant sequence LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- MEM_LATENCY = 3 → rsp_valid exactly 4 cycles after the grant; the next ready no earlier than 5 cycles after the grant.
- rst_n pulsed low during WAIT → all outputs 0 immediately; no rsp_valid ever appears for the aborted access; the next request after reset completes normally.

Source files
------------

// File: rtl/riscv_soc_pkg.sv
// Shared types and constants for the core memory subsystem.
package riscv_soc_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned STRB_W   = XLEN / 8;
   localparam int unsigned STREAK_W = 4;
   localparam int unsigned LAT_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } arb_owner_e;

   // Saturating increment for the LS streak counter.
   function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] v);
      return (v == '1) ? v : v + STREAK_W'(1);
   endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Fixed LS-first priority with a streak cap that forces a waiting fetch through.
module mem_arbiter_grant
   import riscv_soc_pkg::*;
#(
   parameter int unsigned MAX_LS_STREAK = 4
) (
   input  logic                if_valid,
   input  logic                ls_valid,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_if,
   output logic                grant_ls
);

   // LS wins unless it has used up its streak while fetch is waiting.
   always_comb begin
      grant_ls = ls_valid && ((streak < STREAK_W'(MAX_LS_STREAK)) || !if_valid);
      grant_if = if_valid && !grant_ls;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store, one access in flight.
module mem_arbiter
   import riscv_soc_pkg::*;
#(
   parameter int unsigned AW            = 32,
   parameter int unsigned MEM_LATENCY   = 1,
   parameter int unsigned MAX_LS_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   input  logic [AW-1:0]     if_req_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [XLEN-1:0]   if_rsp_rdata,
   input  logic              ls_req_valid,
   input  logic [AW-1:0]     ls_req_addr,
   input  logic              ls_req_we,
   input  logic [STRB_W-1:0] ls_req_wstrb,
   input  logic [XLEN-1:0]   ls_req_wdata,
   output logic              ls_req_ready,
   output logic              ls_rsp_valid,
   output logic [XLEN-1:0]   ls_rsp_rdata,
   output logic              mem_en,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [AW-3:0]     mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata
);

   arb_state_e          state_q, state_d;
   arb_owner_e          owner_q, owner_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                ls_we_q, ls_we_d;
   logic                grant_if, grant_ls;
   logic                capture_c;

   // Byte offsets are irrelevant to a word-wide SRAM.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{if_req_addr[1:0], ls_req_addr[1:0]};

   mem_arbiter_grant #(
      .MAX_LS_STREAK (MAX_LS_STREAK)
   ) u_grant (
      .if_valid (if_req_valid),
      .ls_valid (ls_req_valid),
      .streak   (streak_q),
      .grant_if (grant_if),
      .grant_ls (grant_ls)
   );

   // FSM, owner, latency and streak registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= OWN_IF;
         lat_cnt_q <= '0;
         streak_q  <= '0;
         ls_we_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
         streak_q  <= streak_d;
         ls_we_q   <= ls_we_d;
      end
   end

   // Next state, grant handshake and SRAM strobe; the request path is held off during reset.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_cnt_d    = lat_cnt_q;
      streak_d     = streak_q;
      ls_we_d      = ls_we_q;
      capture_c    = 1'b0;
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
      mem_en       = 1'b0;
      mem_wstrb    = '0;
      mem_addr     = '0;
      mem_wdata    = '0;

      case (state_q)
         ST_IDLE: begin
            if (rst_n && grant_ls) begin
               ls_req_ready = 1'b1;
               mem_en       = 1'b1;
               mem_addr     = ls_req_addr[AW-1:2];
               mem_wstrb    = ls_req_we ? ls_req_wstrb : '0;
               mem_wdata    = ls_req_wdata;
               owner_d      = OWN_LS;
               ls_we_d      = ls_req_we;
               lat_cnt_d    = LAT_W'(MEM_LATENCY - 1);
               streak_d     = if_req_valid ? streak_sat_inc(streak_q) : '0;
               state_d      = ST_WAIT;
            end else if (rst_n && grant_if) begin
               if_req_ready = 1'b1;
               mem_en       = 1'b1;
               mem_addr     = if_req_addr[AW-1:2];
               owner_d      = OWN_IF;
               ls_we_d      = 1'b0;
               lat_cnt_d    = LAT_W'(MEM_LATENCY - 1);
               streak_d     = '0;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == '0) begin
               capture_c = 1'b1;
               state_d   = ST_RESP;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response registers: valid pulses during RESP, data holds until the next response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rsp_valid <= 1'b0;
         if_rsp_rdata <= '0;
         ls_rsp_valid <= 1'b0;
         ls_rsp_rdata <= '0;
      end else begin
         if_rsp_valid <= capture_c && (owner_q == OWN_IF);
         ls_rsp_valid <= capture_c && (owner_q == OWN_LS);
         if (capture_c && (owner_q == OWN_IF)) begin
            if_rsp_rdata <= mem_rdata;
         end
         if (capture_c && (owner_q == OWN_LS)) begin
            ls_rsp_rdata <= ls_we_q ? '0 : mem_rdata;
         end
      end
   end

endmodule
